i2s_dac_serializer: RTL and testbench
=====================================

Name: i2s_dac_serializer

Overview:
- Downstream neighbour of the resampling stage in the adc_dac path.
- Accepts 24-bit signed samples through a valid/ready handshake and buffers them in a small FIFO.
- Serializes each sample onto a standard I2S link (bclk, lrck, sdata) for the DAC, with the mono sample duplicated on the left and right slots.
- Generates bclk and lrck internally by dividing the system clock.

Parameters:
- SAMPLE_W, 24, sample width in bits. Matches the resampler output.
- SLOT_W, 32, bclk periods per channel slot. Must be at least SAMPLE_W+1.
- BCLK_DIV, 4, clk cycles per bclk half-period. Must be at least 1.
- FIFO_DEPTH, 4, input FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enn  in  1  serializer enable; 1 = run
- s_data  in  SAMPLE_W  signed sample from the resampler
- s_valid  in  1  s_data is valid
- s_ready  out  1  FIFO can accept a sample
- bclk  out  1  I2S bit clock
- lrck  out  1  I2S word select; 0 = left, 1 = right
- sdata  out  1  I2S serial data, MSB first
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
- underrun  out  1  sticky flag: a frame started with the FIFO empty

Behaviour:
- Reset (asynchronous, rst_n=0):
  - bclk=0, lrck=0, sdata=0, underrun=0, fifo_level=0, s_ready=1.
  - Divider, bit counter, shift register and FIFO pointers cleared.
- Push: occurs on a clk edge when s_valid && s_ready.
  - s_ready = !full, registered from the FIFO level.
  - No combinational path from s_valid to s_ready.
- Divider (enn=1):
  - div_cnt counts 0..BCLK_DIV-1; bclk toggles at each wrap.
  - A "fall event" is the clk edge on which bclk goes 1->0.
- bit_cnt runs 0..2*SLOT_W-1 and advances on each fall event, wrapping to 0.
- All sdata and lrck updates happen only on fall events, so the DAC samples on the bclk rising edge.
- lrck is 0 while bit_cnt < SLOT_W and 1 otherwise.
- sdata within a slot, with k = bit_cnt mod SLOT_W:
  - k=0: 0 (I2S one-bit delay).
  - k=1..SAMPLE_W: shreg[SAMPLE_W-k] (MSB first).
  - k > SAMPLE_W: 0 (padding).
  - The right slot replays the same shreg.
- Frame start: the fall event that wraps bit_cnt to 0, plus the first clk edge after enn rises with the block idle. At frame start:
  - FIFO not empty: pop the head into shreg.
  - FIFO empty: load shreg=0 and set underrun=1.
  - underrun clears only on reset.
- Simultaneous push and pop in one cycle: both occur; fifo_level is unchanged.
- A push into an empty FIFO on the same cycle as frame start is not bypassed: the frame plays zeros and underrun is set.
- enn=0:
  - Next clk edge: bclk=0, lrck=0, sdata=0; div_cnt and bit_cnt cleared.
  - FIFO contents and the push handshake are retained.
- enn rising: a new frame starts from bit_cnt=0 with a frame-start load.
- enn is assumed to be synchronous to clk.
- Reset mid-frame: all outputs go to their reset values immediately and FIFO contents are discarded.
- Frame rate = clk / (2*BCLK_DIV*2*SLOT_W).
- Latency: a sample popped at frame start presents its MSB on sdata at the next fall event, bit_cnt=1.

Decomposition:
- Package adc_dac_pkg holds:
  - SAMPLE_W and SLOT_W defaults.
  - FRAME_BITS = 2*SLOT_W.
  - The sample type (signed [SAMPLE_W-1:0]).
- Sub-module sample_fifo: synchronous FIFO of FIFO_DEPTH x SAMPLE_W with push, pop, full, empty and level.
  - Instantiated once.
  - The divider, counters and shifter stay in the top module.

Test Plan:
- Reset with enn=0 -> bclk=lrck=sdata=0, s_ready=1, fifo_level=0, underrun=0.
- Push 24'hA5F00F, then enn=1 (BCLK_DIV=2) -> bclk period is 4 clk; the left slot shows 0, then 1010_0101_1111_0000_0000_1111, then 7 zeros; the right slot repeats it; lrck toggles every 32 bclk.
- Push 5 samples with enn=0 -> s_ready drops after the 4th push, fifo_level=4, and the 5th is not accepted while s_valid is held; enable -> each frame pops one sample and level decrements 4->3.
- enn=1 with an empty FIFO -> first frame sdata is all 0 and underrun=1; a later push of 24'h800000 plays in the next frame while underrun stays 1.
- Push 24'h000001 into an empty FIFO on the same cycle as frame start -> that frame is zeros with underrun=1; the next frame outputs the LSB 1 at k=24.
- Assert rst_n=0 mid-left-slot -> outputs go to 0 asynchronously and fifo_level=0; release with enn=1 -> a new frame begins and lrck=0.

Source files
------------

// File: rtl/adc_dac_pkg.sv
// Shared widths and types for the adc_dac audio path.
// Latency: n/a (declarations only); backpressure: n/a.
package adc_dac_pkg;

    localparam int SAMPLE_W_DEF = 24;
    localparam int SLOT_W_DEF   = 32;
    localparam int FRAME_BITS   = 2 * SLOT_W_DEF;

    typedef logic signed [SAMPLE_W_DEF-1:0] sample_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_e;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with registered occupancy; head word readable combinationally.
// Latency: push visible at head next cycle; backpressure: push ignored when full, pop ignored when empty.
module sample_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (level_q == FULL_LVL);
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/i2s_dac_serializer.sv
// Buffers mono samples and plays each on both I2S slots; MSB appears on the fall event after the frame-start pop.
// Backpressure: s_ready = !full from the registered FIFO level; an empty FIFO at frame start plays zeros and sets underrun.
module i2s_dac_serializer import adc_dac_pkg::*; #(
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int SLOT_W     = SLOT_W_DEF,
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enn,
    input  logic [SAMPLE_W-1:0]           s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          bclk,
    output logic                          lrck,
    output logic                          sdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun
);

    localparam int FRAME_N = 2 * SLOT_W;
    localparam int BCW     = $clog2(FRAME_N);
    localparam int DIVW    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(BCLK_DIV - 1);
    localparam logic [BCW-1:0]  BIT_LAST = BCW'(FRAME_N - 1);
    localparam logic [BCW-1:0]  SLOT_N   = BCW'(SLOT_W);

    run_state_e            state_q;
    logic [DIVW-1:0]       div_cnt_q;
    logic                  bclk_q;
    logic [BCW-1:0]        bit_cnt_q;
    logic                  lrck_q;
    logic                  sdata_q;
    logic [SAMPLE_W-1:0]   shreg_q;
    logic                  underrun_q;

    logic                  div_wrap;
    logic                  fall_evt;
    logic                  frame_start;
    logic [BCW-1:0]        bit_nxt;
    logic [BCW-1:0]        slot_k;
    logic                  lrck_d;
    logic                  sdata_d;
    logic [SAMPLE_W-1:0]   fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (s_valid),
        .push_dat_i (s_data),
        .pop_i      (frame_start),
        .pop_dat_o  (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level)
    );

    assign div_wrap    = (div_cnt_q == DIV_LAST);
    assign fall_evt    = div_wrap && bclk_q;
    assign bit_nxt     = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
    assign frame_start = enn && ((state_q == ST_IDLE) || (fall_evt && (bit_cnt_q == BIT_LAST)));
    assign lrck_d      = (bit_nxt >= SLOT_N);

    // k=0 is the I2S one-bit delay and k>SAMPLE_W is padding; neither matches any shreg bit.
    always_comb begin
        slot_k  = (bit_nxt >= SLOT_N) ? bit_nxt - SLOT_N : bit_nxt;
        sdata_d = 1'b0;
        for (int i = 0; i < SAMPLE_W; i++) begin
            if (int'(slot_k) == SAMPLE_W - i) sdata_d = shreg_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= '0;
            bclk_q     <= 1'b0;
            bit_cnt_q  <= '0;
            lrck_q     <= 1'b0;
            sdata_q    <= 1'b0;
            shreg_q    <= '0;
            underrun_q <= 1'b0;
        end else if (!enn) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= '0;
            lrck_q    <= 1'b0;
            sdata_q   <= 1'b0;
        end else begin
            state_q   <= ST_RUN;
            div_cnt_q <= div_wrap ? '0 : div_cnt_q + 1'b1;
            if (div_wrap) bclk_q <= ~bclk_q;
            if (fall_evt) begin
                bit_cnt_q <= bit_nxt;
                lrck_q    <= lrck_d;
                sdata_q   <= sdata_d;
            end
            // A same-cycle push into an empty FIFO is deliberately not bypassed.
            if (frame_start) begin
                shreg_q <= fifo_empty ? '0 : fifo_head;
                if (fifo_empty) underrun_q <= 1'b1;
            end
        end
    end

    assign s_ready  = !fifo_full;
    assign bclk     = bclk_q;
    assign lrck     = lrck_q;
    assign sdata    = sdata_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// Bench for i2s_dac_serializer: a DAC-side receiver captures (lrck, sdata) on each bclk rise.
// Expected frames come from a sample queue and the I2S slot layout {0, sample, padding}.
module tb_i2s_dac_serializer;
    import adc_dac_pkg::*;

    localparam int D    = 2;
    localparam int SW   = 24;
    localparam int FB   = FRAME_BITS;
    localparam int LIM  = 64;
    localparam logic [63:0] EXP_LR = {32'h0000_0000, 32'hFFFF_FFFF};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enn;
    logic [SW-1:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        bclk;
    logic        lrck;
    logic        sdata;
    logic [2:0]  fifo_level;
    logic        underrun;

    int n_pass  = 0;
    int n_total = 0;
    logic [SW-1:0] mq [$];
    logic          und_m;

    always #5 clk = ~clk;

    i2s_dac_serializer #(
        .SAMPLE_W   (SW),
        .SLOT_W     (32),
        .BCLK_DIV   (D),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enn        (enn),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .bclk       (bclk),
        .lrck       (lrck),
        .sdata      (sdata),
        .fifo_level (fifo_level),
        .underrun   (underrun)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] exp_frame(input logic [SW-1:0] s);
        logic [31:0] slot;
        slot = {1'b0, s, 7'b0};
        return {slot, slot};
    endfunction

    task automatic model_start(output logic [SW-1:0] e);
        if (mq.size() > 0) begin
            e = mq.pop_front();
        end else begin
            e     = '0;
            und_m = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        enn     = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mq.delete();
        und_m = 1'b0;
    endtask

    task automatic push(input logic [SW-1:0] d);
        logic acc;
        chk("s_ready_pre_push", 64'(s_ready), 64'(mq.size() < 4));
        acc     = s_ready;
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        s_valid = 1'b0;
        if (acc) mq.push_back(d);
    endtask

    task automatic get_bit(output logic lr, output logic sd, output int gap);
        logic prev;
        logic got;
        prev = bclk;
        got  = 1'b0;
        gap  = 0;
        while (!got && gap < LIM) begin
            @(negedge clk);
            gap++;
            if (!prev && bclk) got = 1'b1;
            prev = bclk;
        end
        lr = lrck;
        sd = sdata;
        if (!got) chk("bclk_rise_timeout", 64'(got), 64'd1);
    endtask

    task automatic play_frame(input logic [SW-1:0] e, input logic do_push,
                              input logic [SW-1:0] pdat, input logic stop);
        logic [63:0] lrv;
        logic [63:0] sdv;
        logic lr, sd, rdy;
        int   g;
        int   gmin = 1000;
        int   gmax = 0;
        for (int b = 0; b < FB; b++) begin
            get_bit(lr, sd, g);
            lrv[63-b] = lr;
            sdv[63-b] = sd;
            if (b >= 1 && b <= 9) begin
                if (g < gmin) gmin = g;
                if (g > gmax) gmax = g;
            end
            if (do_push && b == 10) begin
                chk("s_ready_mid_frame", 64'(s_ready), 64'(mq.size() < 4));
                rdy     = s_ready;
                s_valid = 1'b1;
                s_data  = pdat;
                @(negedge clk);
                s_valid = 1'b0;
                if (rdy) mq.push_back(pdat);
            end
        end
        if (stop) enn = 1'b0;
        chk("frame_sdata", sdv, exp_frame(e));
        chk("frame_lrck", lrv, EXP_LR);
        chk("bclk_period_min", 64'(gmin), 64'(2*D));
        chk("bclk_period_max", 64'(gmax), 64'(2*D));
        chk("underrun_after_frame", 64'(underrun), 64'(und_m));
        chk("level_after_frame", 64'(fifo_level), 64'(mq.size()));
    endtask

    initial begin
        logic [SW-1:0] e;
        logic lr, sd;
        int   g;

        // Reset state
        do_reset();
        chk("rst_bclk", 64'(bclk), 64'd0);
        chk("rst_lrck", 64'(lrck), 64'd0);
        chk("rst_sdata", 64'(sdata), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_underrun", 64'(underrun), 64'd0);

        // Single known sample, one frame
        push(24'hA5F00F);
        chk("level_one", 64'(fifo_level), 64'd1);
        enn = 1'b1;
        model_start(e);
        play_frame(e, 1'b0, '0, 1'b1);

        // Fill FIFO beyond capacity while disabled
        for (int i = 0; i < 5; i++) push(SW'($urandom));
        chk("full_level", 64'(fifo_level), 64'd4);
        chk("full_s_ready", 64'(s_ready), 64'd0);
        s_valid = 1'b1;
        s_data  = SW'($urandom);
        repeat (3) begin
            @(negedge clk);
            chk("hold_s_ready", 64'(s_ready), 64'(mq.size() < 4));
            chk("hold_level", 64'(fifo_level), 64'(mq.size()));
        end
        s_valid = 1'b0;
        enn = 1'b1;
        for (int f = 0; f < 4; f++) begin
            model_start(e);
            play_frame(e, 1'b0, '0, f == 3);
        end

        // Underrun with an empty FIFO, then a late push plays next frame
        enn = 1'b1;
        model_start(e);
        play_frame(e, 1'b1, 24'h800000, 1'b0);
        model_start(e);
        play_frame(e, 1'b0, '0, 1'b1);

        // Asynchronous reset in the middle of the left slot
        push(24'hFFFFFF);
        push(24'hFFFFFF);
        enn = 1'b1;
        model_start(e);
        for (int b = 0; b < 6; b++) get_bit(lr, sd, g);
        chk("pre_rst_sdata", 64'(sd), 64'(e[SW-5]));
        #2;
        rst_n = 1'b0;
        mq.delete();
        und_m = 1'b0;
        #1;
        chk("arst_bclk", 64'(bclk), 64'd0);
        chk("arst_lrck", 64'(lrck), 64'd0);
        chk("arst_sdata", 64'(sdata), 64'd0);
        chk("arst_level", 64'(fifo_level), 64'd0);
        chk("arst_underrun", 64'(underrun), 64'd0);
        chk("arst_s_ready", 64'(s_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        model_start(e);
        play_frame(e, 1'b0, '0, 1'b1);

        // Push into an empty FIFO on the frame-start cycle is not bypassed
        do_reset();
        chk("pre_bypass_underrun", 64'(underrun), 64'd0);
        chk("pre_bypass_s_ready", 64'(s_ready), 64'd1);
        enn     = 1'b1;
        s_valid = 1'b1;
        s_data  = 24'h000001;
        model_start(e);
        @(negedge clk);
        s_valid = 1'b0;
        mq.push_back(24'h000001);
        play_frame(e, 1'b0, '0, 1'b0);
        model_start(e);
        play_frame(e, 1'b0, '0, 1'b1);

        // Randomized continuous run with occasional mid-frame pushes
        do_reset();
        push(SW'($urandom));
        push(SW'($urandom));
        enn = 1'b1;
        for (int f = 0; f < 6; f++) begin
            model_start(e);
            play_frame(e, 1'($urandom_range(0, 1)), SW'($urandom), f == 5);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
